// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: requester/response bundle for alu_scheduler.
// Ports: req_valid/req_ready/req_a/req_b/req_op and rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err.
interface alu_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*4-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter feeding one shared, registered ALU.
// Ports: clk, rst_n, bus (requests/response), alu_a/b/op/en, alu_result, busy, op_count.
module alu_scheduler #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_scheduler_if.slave   bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic [CW-1:0]    op_count
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [3:0]       lat_op;
    logic [IDW-1:0]   lat_id;
    logic             lat_err;
    logic             fresh;
    logic [WIDTH-1:0] data_q;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    logic [IDW:0]     sum;
    logic [3:0]       gnt_op;
    logic [IDW-1:0]   gnt_next;

    // Search starts at rr_ptr and wraps; first valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            if (!gnt_found && bus.req_valid[sum[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = sum[IDW-1:0];
            end
        end
    end

    assign gnt_op   = bus.req_op[gnt_id*4 +: 4];
    assign gnt_next = (gnt_id == IDW'(NREQ-1)) ? '0
                    : gnt_id + IDW'(1);

    // Gated by rst_n so no accept strobe leaks out during reset.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE && gnt_found) begin
            bus.req_ready[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_op   <= '0;
            lat_id   <= '0;
            lat_err  <= 1'b0;
            fresh    <= 1'b0;
            data_q   <= '0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fresh <= 1'b0;
                    if (gnt_found) begin
                        lat_a  <= bus.req_a[gnt_id*WIDTH +: WIDTH];
                        lat_b  <= bus.req_b[gnt_id*WIDTH +: WIDTH];
                        lat_op <= gnt_op;
                        lat_id <= gnt_id;
                        rr_ptr <= gnt_next;
                        if (gnt_op >= 4'd12) begin
                            lat_err <= 1'b1;
                            state   <= RESP;
                        end else begin
                            lat_err <= 1'b0;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    fresh <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    // Hold the result locally so rsp_data stays
                    // stable however long the consumer stalls.
                    fresh <= 1'b0;
                    if (fresh) begin
                        data_q <= alu_result;
                    end
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                        if (!lat_err) begin
                            op_count <= op_count + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign alu_en = (state == EXEC);
    assign alu_a  = alu_en ? lat_a  : '0;
    assign alu_b  = alu_en ? lat_b  : '0;
    assign alu_op = alu_en ? lat_op : '0;

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = bus.rsp_valid ? lat_id : '0;
    assign bus.rsp_err   = bus.rsp_valid & lat_err;
    assign bus.rsp_data  = (bus.rsp_valid && !lat_err)
                         ? (fresh ? alu_result : data_q)
                         : '0;
endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (>= 2).
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter CW, default 16, width of the completed-op counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester accept strobe.
REQ-008 SHALL have port req_a  input  NREQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
REQ-010 SHALL have port req_op  input  NREQ*4  opcode; requester i in bits [i*4 +: 4].
REQ-011 SHALL have port rsp_valid  output  1  response valid.
REQ-012 SHALL have port rsp_ready  input  1  response consumed.
REQ-013 SHALL have port rsp_id  output  $clog2(NREQ) (min 1)  index of the requester owning the response.
REQ-014 SHALL have port rsp_data  output  WIDTH  result.
REQ-015 SHALL have port rsp_err  output  1  illegal opcode flag.
REQ-016 SHALL have port alu_a, alu_b  output  WIDTH each  ALU operands.
REQ-017 SHALL have port alu_op  output  4  ALU opcode.
REQ-018 SHALL have port alu_en  output  1  ALU clock-gate enable.
REQ-019 SHALL have port alu_result  input  WIDTH  registered ALU result (one-cycle latency after alu_en).
REQ-020 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-021 SHALL have port op_count  output  CW  completed legal operations.

Function
REQ-022 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-023 In IDLE with any req_valid set, SHALL grant exactly one requester round-robin, starting the search at rr_ptr.
REQ-024 On grant g, SHALL assert req_ready[g] for that one cycle only and latch req_a, req_b, req_op and g.
REQ-025 After grant g, SHALL set rr_ptr to (g+1) mod NREQ; rr_ptr SHALL be unchanged when no grant occurs.
REQ-026 On grant with a legal op (0..11), SHALL go to EXEC.
REQ-027 On grant with an illegal op (12..15), SHALL go directly to RESP with rsp_err=1 and rsp_data=0, without asserting alu_en.
REQ-028 In EXEC, SHALL assert alu_en for exactly one cycle, drive alu_a/alu_b/alu_op from the latched values, then go to RESP.
REQ-029 Outside EXEC, SHALL drive alu_a, alu_b and alu_op to 0 (operand isolation).
REQ-030 In RESP, SHALL assert rsp_valid with rsp_data = alu_result (legal op), rsp_id = latched g, rsp_err as latched.
REQ-031 SHALL hold rsp_valid, rsp_data, rsp_id and rsp_err stable until rsp_ready is sampled high; on that cycle, SHALL return to IDLE.
REQ-032 SHALL accept no new request in EXEC or RESP; req_ready SHALL be 0 in those states.
REQ-033 The earliest re-grant SHALL be the cycle after the rsp_ready handshake (minimum 3 cycles per legal op).
REQ-034 SHALL increment op_count by 1 on each rsp handshake with rsp_err=0, wrapping modulo 2^CW.
REQ-035 In IDLE, rsp_valid, rsp_err and alu_en SHALL be 0.
REQ-036 rsp_data and rsp_id SHALL be 0 outside RESP.
REQ-037 A request deasserted before grant SHALL be dropped with no side effect.

Reset
REQ-038 While rst_n=0, SHALL force state=IDLE, rr_ptr=0, op_count=0, all latches 0 and all outputs 0, asynchronously.
REQ-039 A reset asserted in EXEC or RESP SHALL abort the in-flight operation with no response and no count.
REQ-040 The first grant after reset release SHALL be evaluated on the first rising clk with rst_n=1.

Verification
REQ-041 Bench SHALL cover: single requester 0, op=0 (ADD), A=0x0005, B=0x0003, rsp_ready=1 -> req_ready[0] pulse, alu_en one cycle, rsp_valid 2 cycles after grant, rsp_data=0x0008, rsp_id=0, op_count=1.
REQ-042 Bench SHALL cover: all four req_valid held high with legal ops -> grant order 0,1,2,3,0 and exactly one req_ready bit per grant.
REQ-043 Bench SHALL cover: requester 2, op=0xC -> alu_en never asserted, rsp_err=1, rsp_data=0, op_count unchanged.
REQ-044 Bench SHALL cover: rsp_ready low for 5 cycles in RESP -> response fields stable, req_ready all 0, busy=1, then IDLE the cycle after handshake.
REQ-045 Bench SHALL cover: rst_n pulsed low during EXEC -> outputs 0 immediately, no rsp_valid, next grant goes to requester 0.
REQ-046 Bench SHALL cover: op_count preloaded by 2^CW-1 legal ops, then one more -> op_count=0.
